// File: rtl/cpu8_led_core.sv
// cpu8_led_core: 8-bit accumulator-style CPU driving the Tang Nano LEDs.
// Eight 8-bit registers r0..r7, Z flag, ADDR_W-bit PC. Each instruction takes
// two clocks: FETCH presents PC to the synchronous BSRAM, EXEC decodes the
// returned word (low byte only) and updates registers, flag and PC.
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   counter    free-running counter, used only for matrix row scanning
//   dout       BSRAM read data, bits [15:8] ignored
//   pc_out     instruction address to BSRAM (always equals PC)
//   led        on-board LEDs, active-low, driven from r7[3:0]
//   col        matrix column drive, active-low, driven from the scanned register
//   row        matrix row select, one-hot active-high
//   debug_regs {r7,...,r0} packed, r0 in [7:0]
module cpu8_led_core #(
  parameter int ADDR_W   = 11,
  parameter int SCAN_LSB = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       counter,
  input  logic [15:0]       dout,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        led,
  output logic [7:0]        col,
  output logic [7:0]        row,
  output logic [63:0]       debug_regs
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                z;
  logic [7:0]          regs [8];

  // Decode / execute datapath
  logic [7:0]          instr;
  logic [7:0]          src;
  logic [7:0]          r0;
  logic                wr_en;
  logic [2:0]          wr_idx;
  logic [7:0]          wr_data;
  logic                z_en;
  logic [ADDR_W-1:0]   pc_next;

  assign instr = dout[7:0];
  assign src   = regs[instr[2:0]];
  assign r0    = regs[0];

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = 3'd0;
    wr_data = 8'h00;
    z_en    = 1'b0;
    pc_next = pc + ADDR_W'(1);
    case (instr[7:6])
      2'b00: begin // MOV rd <= rs
        wr_en   = 1'b1;
        wr_idx  = instr[5:3];
        wr_data = src;
      end
      2'b01: begin // ALU group, always updates Z
        wr_en = 1'b1;
        z_en  = 1'b1;
        case (instr[5:3])
          3'b000:  begin wr_idx = 3'd0;       wr_data = r0 + src;  end
          3'b001:  begin wr_idx = 3'd0;       wr_data = r0 - src;  end
          3'b010:  begin wr_idx = 3'd0;       wr_data = r0 & src;  end
          3'b011:  begin wr_idx = 3'd0;       wr_data = r0 | src;  end
          3'b100:  begin wr_idx = instr[2:0]; wr_data = src + 8'd1; end
          3'b101:  begin wr_idx = instr[2:0]; wr_data = src - 8'd1; end
          3'b110:  begin wr_idx = instr[2:0]; wr_data = ~src;      end
          default: begin wr_idx = instr[2:0]; wr_data = {src[6:0], src[7]}; end
        endcase
      end
      2'b10: begin
        case (instr[5:4])
          2'b00: if (z) pc_next = ADDR_W'(instr[3:0]);   // JZ
          2'b01: pc_next = ADDR_W'(instr[3:0]);          // JMP
          2'b10: begin                                   // MVI
            wr_en   = 1'b1;
            wr_data = {4'h0, instr[3:0]};
          end
          default: begin                                 // MVIH
            wr_en   = 1'b1;
            wr_data = {instr[3:0], r0[3:0]};
          end
        endcase
      end
      default: ; // NOP
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      z     <= 1'b0;
      // NOTE: the register file is eight flops, not a RAM, so clearing it on
      // reset is cheap and makes the LED outputs defined from the start.
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      case (state)
        FETCH: state <= EXEC;
        default: begin
          state <= FETCH;
          pc    <= pc_next;
          if (wr_en) regs[wr_idx] <= wr_data;
          if (z_en)  z <= (wr_data == 8'h00);
        end
      endcase
    end
  end

  assign pc_out = pc;

  always_comb begin
    debug_regs = '0;
    for (int i = 0; i < 8; i++) debug_regs[i*8 +: 8] = regs[i];
  end

  // Display outputs: combinational from registers, forced dark while in reset.
  logic [2:0] idx;
  assign idx = counter[SCAN_LSB +: 3];
  assign row = 8'(1) << idx;
  assign col = rst ? 8'hFF : ~regs[idx];
  assign led = rst ? 4'hF  : ~regs[7][3:0];

endmodule

// File: tb/tb_cpu8_led_core.sv
// Directed testbench for cpu8_led_core with a behavioural 1-cycle-latency
// BSRAM. Expected values are hand-computed per program step.
module tb_cpu8_led_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] counter;
  logic [15:0] dout;
  logic [10:0] pc_out;
  logic [3:0]  led;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [63:0] debug_regs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [2048];

  cpu8_led_core #(.ADDR_W(11), .SCAN_LSB(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .counter    (counter),
    .dout       (dout),
    .pc_out     (pc_out),
    .led        (led),
    .col        (col),
    .row        (row),
    .debug_regs (debug_regs)
  );

  always #5 clk = ~clk;

  // Synchronous single-port ROM, one cycle read latency.
  always @(posedge clk) dout <= mem[pc_out];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] r(input int i);
    return debug_regs[i*8 +: 8];
  endfunction

  // Upper byte filled with junk: the core must ignore dout[15:8].
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hA500;
  endtask

  task automatic load(input int addr, input logic [7:0] b);
    mem[addr] = {8'hC3, b};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One FETCH/EXEC pair, sampled 1ns after the EXEC edge.
  task automatic step();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    counter = 24'd0;
    clear_mem();

    // ---- Reset state and MVI/ROL sequence ----
    load(0, 8'hA1);
    for (int i = 1; i <= 8; i++) load(i, 8'h78);
    counter = 24'(5) << 13;
    repeat (2) @(posedge clk); #1;
    check("rst_pc",   pc_out, 0);
    check("rst_regs", debug_regs, 0);
    check("rst_led",  led, 4'hF);
    check("rst_col",  col, 8'hFF);
    check("rst_row",  row, 8'b0010_0000);
    rst = 1'b0;
    step();
    check("first_pc", pc_out, 1);
    check("mvi1_r0",  r(0), 8'h01);
    step(); check("rol_2",   r(0), 8'h02);
    step(); check("rol_4",   r(0), 8'h04);
    step(); check("rol_8",   r(0), 8'h08);
    repeat (4) step();
    check("rol_80",  r(0), 8'h80);
    step(); check("rol_wrap", r(0), 8'h01);
    check("rol_pc",  pc_out, 9);

    // ---- Loop program with MOV / INC / JMP ----
    clear_mem();
    load(0, 8'h66); load(1, 8'h08); load(2, 8'h61); load(3, 8'h39); load(4, 8'h90);
    do_reset();
    step(); check("inc_r6", r(6), 8'h01);
    step(); check("mov_r1", r(1), 8'h00);
    step(); check("inc_r1", r(1), 8'h01);
    step(); check("mov_r7", r(7), 8'h01);
    check("led_r7", led, 4'b1110);
    step(); check("jmp_pc", pc_out, 0);
    repeat (5) step();
    check("loop2_r6", r(6), 8'h02);
    check("loop2_r7", r(7), 8'h01);
    check("loop2_pc", pc_out, 0);

    // ---- Flags, jumps, immediates, logic ops ----
    clear_mem();
    load(0, 8'h68);  // DEC r0
    load(1, 8'h85);  // JZ 5 (not taken)
    load(2, 8'h60);  // INC r0
    load(3, 8'h85);  // JZ 5 (taken)
    load(5, 8'hAA);  // MVI 0xA
    load(6, 8'hB5);  // MVIH 0x5
    load(7, 8'h70);  // NOT r0
    load(8, 8'h10);  // MOV r2,r0
    load(9, 8'hAF);  // MVI 0xF
    load(10, 8'h08); // MOV r1,r0
    load(11, 8'h02); // MOV r0,r2
    load(12, 8'h51); // AND r1
    load(13, 8'h02); // MOV r0,r2
    load(14, 8'h59); // OR r1
    load(15, 8'h41); // ADD r1
    load(16, 8'h48); // SUB r0
    load(17, 8'hA3); // MVI 3 (Z held)
    load(18, 8'h89); // JZ 9
    do_reset();
    step(); check("dec_r0",   r(0), 8'hFF);
    step(); check("jz_nt_pc", pc_out, 2);
    step(); check("inc_wrap", r(0), 8'h00);
    step(); check("jz_t_pc",  pc_out, 5);
    step(); check("mvi_a",    r(0), 8'h0A);
    step(); check("mvih_5",   r(0), 8'h5A);
    step(); check("not_r0",   r(0), 8'hA5);
    repeat (3) step();
    check("r1_0f",    r(1), 8'h0F);
    check("r2_a5",    r(2), 8'hA5);
    step(); check("mov_back", r(0), 8'hA5);
    step(); check("and_r1",   r(0), 8'h05);
    step();
    step(); check("or_r1",    r(0), 8'hAF);
    step(); check("add_r1",   r(0), 8'hBE);
    step(); check("sub_self", r(0), 8'h00);
    step(); check("mvi_3",    r(0), 8'h03);
    step(); check("jz_hold",  pc_out, 9);

    // ---- PC wrap at 0x7FF ----
    clear_mem();
    load(2047, 8'hC0); // NOP
    do_reset();
    repeat (2047) step();
    check("pc_7ff",  pc_out, 11'h7FF);
    step();
    check("pc_wrap", pc_out, 0);
    check("wrap_regs", debug_regs, 0);

    // ---- Matrix scan and mid-instruction reset ----
    clear_mem();
    load(0, 8'hAC); load(1, 8'hB3); load(2, 8'h18); load(3, 8'h66); load(4, 8'h93);
    counter = 24'(3) << 13;
    do_reset();
    repeat (3) step();
    check("r3_3c",   r(3), 8'h3C);
    check("row_3",   row, 8'b0000_1000);
    check("col_3",   col, 8'hC3);
    repeat (3) step();
    check("loop_r6", r(6), 8'h02);
    @(posedge clk); #1;            // FETCH done, EXEC pending
    rst = 1'b1;
    #1;
    check("rst_col_gate", col, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_regs", debug_regs, 0);
    check("mid_rst_pc",   pc_out, 0);
    step();
    check("restart_r0", r(0), 8'h0C);
    check("restart_pc", pc_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu8_led_core.md
Name: cpu8_led_core

Overview:
- 8-bit accumulator-style CPU with eight 8-bit registers r0..r7, an 11-bit PC and an 8-bit instruction set.
- Instructions are fetched from an external single-port synchronous BSRAM (Gowin_SP class, 16-bit words, 1-cycle read latency, same clock); only dout[7:0] is decoded.
- Drives the 4 on-board LEDs and an 8x8 LED matrix directly from register contents, for the Tang Nano LED demo.

Parameters:
- ADDR_W, 11, program counter / memory address width
- SCAN_LSB, 13, lowest counter bit used for matrix row scanning

Ports:
- clk  input  1  single system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- counter  input  24  free-running system counter, used only for matrix scan
- dout  input  16  BSRAM read data; bits [15:8] ignored
- pc_out  output  11  instruction address to BSRAM
- led  output  4  on-board LEDs, active-low
- col  output  8  matrix column drive, active-low
- row  output  8  matrix row select, one-hot active-high
- debug_regs  output  64  {r7,...,r0} packed, r0 in [7:0], combinational from the register file

Behaviour:
- One clock, synchronous active-high reset (already decided). Reset forces PC=0, r0..r7=0, Z flag=0, state=FETCH.
- Two-state FSM:
  - FETCH: pc_out=PC; BSRAM registers the word; go to EXEC.
  - EXEC: decode dout[7:0], update registers, flag and PC; go to FETCH.
  - One instruction per 2 clk cycles.
- pc_out always equals PC. PC increments mod 2^11, so 0x7FF wraps to 0x000.
- Encoding, with s/d/r as 3-bit register indices:
  - 00dddsss MOV rd<=rs
  - 01000rrr ADD r0<=r0+rr
  - 01001rrr SUB r0<=r0-rr
  - 01010rrr AND r0<=r0&rr
  - 01011rrr OR r0<=r0|rr
  - 01100rrr INC rr<=rr+1
  - 01101rrr DEC rr<=rr-1
  - 01110rrr NOT rr<=~rr
  - 01111rrr ROL rr<={rr[6:0],rr[7]}
  - 1000aaaa JZ: if Z, PC<=aaaa (zero-extended), else PC+1
  - 1001aaaa JMP: PC<=aaaa zero-extended
  - 1010iiii MVI r0<={4'b0,iiii}
  - 1011iiii MVIH r0[7:4]<=iiii, r0[3:0] kept
  - 11xxxxxx NOP
- Arithmetic is 8-bit modulo: 0xFF+1=0x00, 0x00-1=0xFF. There is no carry.
- Z flag = (8-bit result == 0). It is updated only by ADD, SUB, AND, OR, INC, DEC, NOT and ROL. It holds across MOV, MVI, MVIH, jumps and NOP.
- MOV rd,rd is a no-op. An ALU op whose source register equals r0 uses the pre-update value.
- Non-jump instructions set PC<=PC+1 in EXEC.
- LED and matrix outputs are combinational from registers, with no extra latency:
  - led = ~r7[3:0]
  - idx = counter[SCAN_LSB+2:SCAN_LSB]
  - row = 8'b1<<idx
  - col = ~r[idx]
- Under reset, led=4'hF, col=8'hFF, and row follows counter.
- Reset mid-instruction abandons the instruction; there is no partial register write.

Test Plan:
- Reset then release:
  - pc_out=0, debug_regs=0, led=4'hF.
  - After the first FETCH/EXEC pair, pc_out=1.
- Program "MVI 1; ROL r0; ROL r0; ROL r0" (0xA1,0x78,0x78,0x78):
  - r0 after each EXEC = 1, 2, 4, 8.
  - ROL of 0x80 gives 0x01.
- Program "INC r6; MOV r1,r0; INC r1; MOV r7,r1; JMP 0" (0x66,0x08,0x61,0x39,0x90):
  - First pass: r6=1, r1=1, r7=1, led=4'b1110, pc_out returns to 0.
  - r6 increments each loop.
- DEC r0 from 0 -> r0=0xFF, Z=0. INC r0 from 0xFF -> r0=0, Z=1. A following JZ 5 lands at pc_out=5; JZ with Z=0 falls through to PC+1.
- MVI 0xA; MVIH 0x5 -> r0=0x5A. NOT r0 -> 0xA5. AND and OR with r1=0x0F -> 0x05 and 0xAF respectively.
- r3=0x3C, counter=3<<13 -> row=8'b0000_1000, col=8'hC3. Assert rst for one cycle mid-program -> all registers and PC are 0 on the next cycle.
